// File: rtl/button_step_scheduler.sv
// rtl/button_step_scheduler.sv - debounced push-button to step/clear pulse scheduler
// Four active-low buttons become one-cycle Step_Up/Step_Down/Clear pulses with hold-to-repeat.
module button_step_scheduler #(
   parameter int ClockPeriod_ns    = 20,
   parameter int FilterPeriod_ns   = 100,
   parameter int PauseInterval_ns  = 2500,
   parameter int RepeatsInterval_ns = 1500,
   parameter int Channels          = 4
) (
   input  logic                        Clock,
   input  logic                        Reset_n,
   input  logic                        Button_Up,
   input  logic                        Button_Down,
   input  logic                        Button_Clear,
   input  logic                        Button_Select,
   output logic                        Step_Up,
   output logic                        Step_Down,
   output logic                        Clear,
   output logic [$clog2(Channels)-1:0] Channel,
   output logic [Channels-1:0]         Channel_Strobe
);

   localparam int FilterCycles = FilterPeriod_ns / ClockPeriod_ns;
   localparam int PauseCycles  = PauseInterval_ns / ClockPeriod_ns;
   localparam int RepeatCycles = RepeatsInterval_ns / ClockPeriod_ns;
   localparam int MaxCycles    = (PauseCycles > RepeatCycles) ? PauseCycles : RepeatCycles;
   localparam int TimerW       = $clog2(MaxCycles);
   localparam int FiltW        = $clog2(FilterCycles + 1);
   localparam int ChW          = $clog2(Channels);

   typedef enum logic [1:0] {IDLE, PAUSE, REPEAT, BLOCKED} state_t;

   // Button order: 0 up, 1 down, 2 clear, 3 select; all active-low.
   logic [3:0]       raw;
   logic [3:0]       sync1, sync2, filt, filt_d, press_q, armed;
   logic [FiltW-1:0] fcnt [4];
   logic [1:0]       warm;

   assign raw = {Button_Select, Button_Clear, Button_Down, Button_Up};

   // A button is armed only once a real released sample is seen, so a
   // button held through reset never produces a press edge on release.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         sync1   <= '1;
         sync2   <= '1;
         filt    <= '1;
         filt_d  <= '1;
         press_q <= '0;
         armed   <= '0;
         warm    <= '0;
         for (int i = 0; i < 4; i++) fcnt[i] <= '0;
      end else begin
         sync1  <= raw;
         sync2  <= sync1;
         filt_d <= filt;
         warm   <= {warm[0], 1'b1};
         for (int i = 0; i < 4; i++) begin
            press_q[i] <= filt_d[i] & ~filt[i] & armed[i];
            armed[i]   <= armed[i] | (warm[1] & sync2[i] & filt[i]);
            if (sync2[i] != filt[i]) begin
               if (fcnt[i] == FiltW'(FilterCycles - 1)) begin
                  filt[i] <= sync2[i];
                  fcnt[i] <= '0;
               end else begin
                  fcnt[i] <= fcnt[i] + 1'b1;
               end
            end else begin
               fcnt[i] <= '0;
            end
         end
      end
   end

   logic up_p, down_p, clear_p;
   logic up_e, down_e, clear_e, sel_e;

   assign up_p    = ~filt[0];
   assign down_p  = ~filt[1];
   assign clear_p = ~filt[2];
   assign up_e    = press_q[0];
   assign down_e  = press_q[1];
   assign clear_e = press_q[2];
   assign sel_e   = press_q[3];

   state_t              state, state_n;
   logic                dir, dir_n;            // 0 = up, 1 = down
   logic [TimerW-1:0]   timer, timer_n;
   logic                up_q, up_n, dn_q, dn_n, clr_q, clr_n;
   logic [ChW-1:0]      channel, chan_n;
   logic [Channels-1:0] strobe_q, strobe_n;
   logic                dir_held, opp_held;

   assign dir_held = dir ? down_p : up_p;
   assign opp_held = dir ? up_p : down_p;

   always_comb begin
      state_n  = state;
      dir_n    = dir;
      timer_n  = timer;
      up_n     = 1'b0;
      dn_n     = 1'b0;
      clr_n    = clear_e;
      chan_n   = channel;
      strobe_n = '0;
      if (clear_p) begin
         state_n = BLOCKED;
      end else if (sel_e && state == IDLE) begin
         chan_n = (channel == ChW'(Channels - 1)) ? '0 : channel + 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (up_e && down_e) begin
                  state_n = BLOCKED;
               end else if (up_e && !down_p) begin
                  up_n    = 1'b1;
                  dir_n   = 1'b0;
                  timer_n = TimerW'(PauseCycles - 1);
                  state_n = PAUSE;
               end else if (down_e && !up_p) begin
                  dn_n    = 1'b1;
                  dir_n   = 1'b1;
                  timer_n = TimerW'(PauseCycles - 1);
                  state_n = PAUSE;
               end
            end
            PAUSE, REPEAT: begin
               if (!dir_held) begin
                  state_n = IDLE;
               end else if (opp_held) begin
                  state_n = BLOCKED;
               end else if (timer == '0) begin
                  up_n    = ~dir;
                  dn_n    = dir;
                  timer_n = TimerW'(RepeatCycles - 1);
                  state_n = REPEAT;
               end else begin
                  timer_n = timer - 1'b1;
               end
            end
            BLOCKED: begin
               if (!up_p && !down_p) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
      if (up_n || dn_n || clr_n) strobe_n[channel] = 1'b1;
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= IDLE;
         dir      <= 1'b0;
         timer    <= '0;
         up_q     <= 1'b0;
         dn_q     <= 1'b0;
         clr_q    <= 1'b0;
         channel  <= '0;
         strobe_q <= '0;
      end else begin
         state    <= state_n;
         dir      <= dir_n;
         timer    <= timer_n;
         up_q     <= up_n;
         dn_q     <= dn_n;
         clr_q    <= clr_n;
         channel  <= chan_n;
         strobe_q <= strobe_n;
      end
   end

   assign Step_Up        = up_q;
   assign Step_Down      = dn_q;
   assign Clear          = clr_q;
   assign Channel        = channel;
   assign Channel_Strobe = strobe_q;

endmodule

// File: tb/tb_button_step_scheduler.sv
// tb/tb_button_step_scheduler.sv - scoreboard bench for button_step_scheduler
module tb_button_step_scheduler;

   logic       Clock = 1'b0;
   logic       Reset_n = 1'b0;
   logic       Button_Up = 1'b1, Button_Down = 1'b1, Button_Clear = 1'b1, Button_Select = 1'b1;
   logic       Step_Up, Step_Down, Clear;
   logic [1:0] Channel;
   logic [3:0] Channel_Strobe;

   button_step_scheduler dut (
      .Clock         (Clock),
      .Reset_n       (Reset_n),
      .Button_Up     (Button_Up),
      .Button_Down   (Button_Down),
      .Button_Clear  (Button_Clear),
      .Button_Select (Button_Select),
      .Step_Up       (Step_Up),
      .Step_Down     (Step_Down),
      .Clear         (Clear),
      .Channel       (Channel),
      .Channel_Strobe(Channel_Strobe)
   );

   always #10 Clock = ~Clock;

   typedef struct {int cyc; int kind; int strobe;} ev_t;
   ev_t sb[$];

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int pulses = 0;
   int ch = 0;
   int n0, c0, p0, t;

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge Clock);
   endtask

   // kind: 1 = up, 2 = down, 4 = clear
   task automatic push(input int c, input int k);
      sb.push_back('{c, k, 1 << ch});
   endtask

   ev_t        e;
   logic [2:0] kind;
   always @(negedge Clock) begin
      if (Reset_n && (Step_Up || Step_Down || Clear)) begin
         pulses++;
         kind = {Clear, Step_Down, Step_Up};
         check("exclusive", 32'(Step_Up) + 32'(Step_Down) + 32'(Clear), 1);
         if (sb.size() == 0) begin
            check("unexpected_pulse", 32'(kind), 0);
         end else begin
            e = sb.pop_front();
            check("pulse_cycle", cyc, e.cyc);
            check("pulse_kind", 32'(kind), e.kind);
            check("pulse_strobe", 32'(Channel_Strobe), e.strobe);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cycles(3);
      check("rst_step_up", 32'(Step_Up), 0);
      check("rst_step_down", 32'(Step_Down), 0);
      check("rst_clear", 32'(Clear), 0);
      check("rst_channel", 32'(Channel), 0);
      check("rst_strobe", 32'(Channel_Strobe), 0);
      Reset_n = 1'b1;
      cycles(10);

      // long Up hold: first step, pause, then repeats until release
      p0 = pulses;
      n0 = cyc + 1;
      Button_Up = 1'b0;
      push(n0 + 8, 1);
      t = n0 + 8 + 125;
      while (t <= n0 + 650 + 6) begin
         push(t, 1);
         t += 75;
      end
      cycles(650);
      Button_Up = 1'b1;
      cycles(30);
      check("hold_up_count", pulses - p0, 8);
      check("hold_up_drained", sb.size(), 0);

      // short Down press: single step only
      p0 = pulses;
      n0 = cyc + 1;
      Button_Down = 1'b0;
      push(n0 + 8, 2);
      cycles(50);
      Button_Down = 1'b1;
      cycles(30);
      check("down_count", pulses - p0, 1);

      // 60 ns glitch and 3-cycle bounce train
      p0 = pulses;
      Button_Up = 1'b0;
      cycles(3);
      Button_Up = 1'b1;
      cycles(20);
      for (int i = 0; i < 4; i++) begin
         Button_Down = 1'b0;
         cycles(3);
         Button_Down = 1'b1;
         cycles(3);
      end
      cycles(30);
      check("glitch_count", pulses - p0, 0);

      // Up repeating, Down pressed: block until Up re-pressed
      p0 = pulses;
      n0 = cyc + 1;
      Button_Up = 1'b0;
      push(n0 + 8, 1);
      push(n0 + 133, 1);
      push(n0 + 208, 1);
      cycles(220);
      Button_Down = 1'b0;
      cycles(50);
      Button_Down = 1'b1;
      cycles(200);
      Button_Up = 1'b1;
      cycles(20);
      check("opposite_count", pulses - p0, 3);
      n0 = cyc + 1;
      Button_Up = 1'b0;
      push(n0 + 8, 1);
      cycles(40);
      Button_Up = 1'b1;
      cycles(30);
      check("repress_count", pulses - p0, 4);

      // Clear during an Up hold
      p0 = pulses;
      n0 = cyc + 1;
      Button_Up = 1'b0;
      push(n0 + 8, 1);
      push(n0 + 133, 1);
      cycles(180);
      c0 = cyc + 1;
      Button_Clear = 1'b0;
      push(c0 + 8, 4);
      cycles(5);
      Button_Clear = 1'b1;
      cycles(200);
      Button_Up = 1'b1;
      cycles(30);
      check("clear_count", pulses - p0, 3);
      check("clear_drained", sb.size(), 0);

      // Select cycling with wrap
      for (int i = 0; i < 5; i++) begin
         Button_Select = 1'b0;
         cycles(10);
         Button_Select = 1'b1;
         cycles(90);
         ch = (ch + 1) % 4;
         check("select_channel", 32'(Channel), ch);
      end

      // Select ignored in PAUSE; reset in REPEAT with Up held
      p0 = pulses;
      n0 = cyc + 1;
      Button_Up = 1'b0;
      push(n0 + 8, 1);
      push(n0 + 133, 1);
      cycles(30);
      Button_Select = 1'b0;
      cycles(10);
      Button_Select = 1'b1;
      cycles(30);
      check("select_in_pause", 32'(Channel), ch);
      cycles(80);
      Reset_n = 1'b0;
      #1;
      check("midrst_step_up", 32'(Step_Up), 0);
      check("midrst_clear", 32'(Clear), 0);
      check("midrst_channel", 32'(Channel), 0);
      check("midrst_strobe", 32'(Channel_Strobe), 0);
      ch = 0;
      cycles(2);
      Reset_n = 1'b1;
      cycles(300);
      Button_Up = 1'b1;
      cycles(30);
      check("post_reset_count", pulses - p0, 2);
      check("final_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
